uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_tx` serializer among `N_REQ` independent requesters. Each requester offers a byte through a valid/ready handshake. The arbiter latches the granted byte, drives `data_rdy_in`/`tx_data_in` of the `uart_tx` instance, tracks `tx_busy_out`/`tx_done_out`, and reports per-requester completion. It sits between the system's byte producers (debug, telemetry, command responders) and the single UART TX pin.

---
 rtl/uart_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the default byte width
// that the uart_tx serializer and its front-end arbiter must agree on.
package uart_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_BUSY} uart_arb_state_t;

  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, wrapping modulo N. Reusable by any TX/RX dispatcher.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any_gnt
);

  logic [IW-1:0] pos;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    pos     = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!any_gnt && req[pos]) begin
        any_gnt  = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end sharing one uart_tx serializer among N_REQ byte
// producers, with per-requester ready/done/timeout-error pulses.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_BITS      = UART_DATA_BITS,
  parameter int ACCEPT_TIMEOUT = 1024,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(ACCEPT_TIMEOUT) + 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_REQ-1:0]           req_valid_in,
  input  logic [N_REQ*DATA_BITS-1:0] req_data_in,
  output logic [N_REQ-1:0]           req_ready_out,
  output logic [N_REQ-1:0]           req_done_out,
  output logic [N_REQ-1:0]           req_err_out,
  output logic [DATA_BITS-1:0]       tx_data_out,
  output logic                       tx_rdy_out,
  input  logic                       tx_busy_in,
  input  logic                       tx_done_in,
  output logic [IW-1:0]              grant_id_out,
  output logic                       active_out
);

  uart_arb_state_t state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q, err_q;
  logic            take, fin_done, fin_err;
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_valid_in),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_gnt (arb_any)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // A grant is held off while a done/err pulse is showing, so at most one
  // ready/done/err bit is ever set in a cycle.
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    fin_done = 1'b0;
    fin_err  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_any && !done_q && !err_q && !rst_in) begin
          take    = 1'b1;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (tx_busy_in) begin
          state_d = ARB_BUSY;
        end else if (cnt_q == CW'(ACCEPT_TIMEOUT - 1)) begin
          fin_err = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_BUSY: begin
        if (tx_done_in || !tx_busy_in) begin
          fin_done = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tx_data_out  <= '0;
      grant_id_out <= '0;
    end else begin
      done_q <= fin_done;
      err_q  <= fin_err;
      if (take) begin
        tx_data_out  <= req_data_in[int'(arb_idx) * DATA_BITS +: DATA_BITS];
        grant_id_out <= arb_idx;
        ptr_q        <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
        cnt_q        <= '0;
      end else if (state_q == ARB_REQ && !tx_busy_in && cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_out = take ? arb_gnt : '0;
    req_done_out  = done_q ? (N_REQ'(1) << grant_id_out) : '0;
    req_err_out   = err_q  ? (N_REQ'(1) << grant_id_out) : '0;
    tx_rdy_out    = (state_q == ARB_REQ);
    active_out    = (state_q != ARB_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural uart_tx stand-in, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 8, AT = 16, BT = 2, FRAME = 10 * BT;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [N-1:0]    req_valid_in = '0;
  logic [N*DW-1:0] req_data_in = '0;
  logic [N-1:0]    req_ready_out, req_done_out, req_err_out;
  logic [DW-1:0]   tx_data_out;
  logic            tx_rdy_out;
  logic            tx_busy_in = 1'b0;
  logic            tx_done_in = 1'b0;
  logic [1:0]      grant_id_out;
  logic            active_out;

  int n_cmp = 0, n_bad = 0;

  always #5 clk_in = ~clk_in;

  uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DW), .ACCEPT_TIMEOUT(AT)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_valid_in (req_valid_in),
    .req_data_in  (req_data_in),
    .req_ready_out(req_ready_out),
    .req_done_out (req_done_out),
    .req_err_out  (req_err_out),
    .tx_data_out  (tx_data_out),
    .tx_rdy_out   (tx_rdy_out),
    .tx_busy_in   (tx_busy_in),
    .tx_done_in   (tx_done_in),
    .grant_id_out (grant_id_out),
    .active_out   (active_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // uart_tx stand-in: accepts on data_rdy while idle, busy for one frame.
  int            u_cnt = 0;
  logic          u_en = 1'b1;
  logic [DW-1:0] u_byte = '0;
  logic [DW-1:0] line_q[$];

  always @(posedge clk_in) begin
    tx_done_in <= 1'b0;
    if (rst_in) begin
      tx_busy_in <= 1'b0;
      u_cnt      <= 0;
    end else if (!tx_busy_in) begin
      if (tx_rdy_out && u_en) begin
        tx_busy_in <= 1'b1;
        u_cnt      <= 0;
        u_byte     <= tx_data_out;
      end
    end else if (u_cnt == FRAME - 1) begin
      tx_busy_in <= 1'b0;
      tx_done_in <= 1'b1;
      line_q.push_back(u_byte);
    end else begin
      u_cnt <= u_cnt + 1;
    end
  end

  // Reference model: 0 = free, 1 = offering byte to uart, 2 = frame on line.
  int            m_mode = 0, m_ptr = 0, m_owner = 0, m_wait = 0, g;
  logic          m_pd = 1'b0, m_pe = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [N-1:0]  e_rdy, e_done, e_err;
  int gl_q[$], dn_q[$], er_q[$], gid_q[$];
  int cyc = 0, rdy_hi = 0, rdy_rise = -1, err_cyc = -1;
  logic rdy_prev = 1'b0;

  initial forever begin
    @(negedge clk_in);
    cyc++;
    g = -1;
    if (m_mode == 0 && !m_pd && !m_pe && !rst_in)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid_in[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    e_rdy = '0; e_done = '0; e_err = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    if (m_pd)   e_done[m_owner] = 1'b1;
    if (m_pe)   e_err[m_owner] = 1'b1;
    chk("req_ready", req_ready_out, e_rdy);
    chk("req_done", req_done_out, e_done);
    chk("req_err", req_err_out, e_err);
    chk("tx_rdy", tx_rdy_out, m_mode == 1);
    chk("active", active_out, m_mode != 0);
    chk("tx_data", tx_data_out, m_data);
    chk("grant_id", grant_id_out, m_owner);
    for (int k = 0; k < N; k++) begin
      if (req_ready_out[k]) gl_q.push_back(k);
      if (req_done_out[k]) begin dn_q.push_back(k); gid_q.push_back(grant_id_out); end
      if (req_err_out[k]) begin er_q.push_back(k); err_cyc = cyc; end
    end
    if (tx_rdy_out && !rdy_prev) rdy_rise = cyc;
    if (tx_rdy_out) rdy_hi++;
    rdy_prev = tx_rdy_out;
    if (rst_in) begin
      m_mode = 0; m_ptr = 0; m_owner = 0; m_wait = 0; m_data = '0; m_pd = 1'b0; m_pe = 1'b0;
    end else begin
      m_pd = 1'b0; m_pe = 1'b0;
      case (m_mode)
        0: if (g >= 0) begin
             m_owner = g; m_data = req_data_in[g*DW +: DW];
             m_ptr = (g + 1) % N; m_wait = 0; m_mode = 1;
           end
        1: if (tx_busy_in) m_mode = 2;
           else if (m_wait == AT - 1) begin m_pe = 1'b1; m_mode = 0; end
           else m_wait++;
        default: if (tx_done_in || !tx_busy_in) begin m_pd = 1'b1; m_mode = 0; end
      endcase
    end
  end

  function automatic int qsize(input int which);
    case (which)
      0: return gl_q.size();
      1: return dn_q.size();
      2: return er_q.size();
      4: return gid_q.size();
      default: return line_q.size();
    endcase
  endfunction

  function automatic int qget(input int which, input int idx);
    if (idx >= qsize(which)) return -1;
    case (which)
      0: return gl_q[idx];
      1: return dn_q[idx];
      2: return er_q[idx];
      4: return gid_q[idx];
      default: return int'(line_q[idx]);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_for(input int which, input int target, input int budget, input string nm);
    int waited = 0;
    while (qsize(which) < target && waited < budget) begin
      @(negedge clk_in); #1;
      waited++;
    end
    chk(nm, qsize(which) >= target, 1);
  endtask

  task automatic wait_busy(input string nm);
    int waited = 0;
    while (!(active_out && tx_busy_in) && waited < 20) begin
      @(negedge clk_in); #1;
      waited++;
    end
    chk(nm, active_out && tx_busy_in, 1);
  endtask

  task automatic offer(input int i, input logic [DW-1:0] b);
    req_valid_in[i] = 1'b1;
    req_data_in[i*DW +: DW] = b;
  endtask

  task automatic clear_logs();
    gl_q.delete(); dn_q.delete(); er_q.delete(); gid_q.delete(); line_q.delete();
    rdy_hi = 0;
  endtask

  task automatic drop_all();
    @(posedge clk_in); #1;
    req_valid_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("reset tx_data", tx_data_out, 0);
    chk("reset grant_id", grant_id_out, 0);
    chk("reset active", active_out, 0);
    chk("reset tx_rdy", tx_rdy_out, 0);
    rst_in = 1'b0;
    tick(2);

    // single requester
    clear_logs();
    offer(2, 8'hA5);
    wait_for(0, 1, 20, "single grant");
    drop_all();
    wait_for(1, 1, 60, "single done");
    chk("single grant idx", qget(0, 0), 2);
    chk("single done idx", qget(1, 0), 2);
    chk("single line byte", qget(3, 0), 32'hA5);
    chk("single grant_id", grant_id_out, 2);
    chk("single rdy cycles", rdy_hi, 2);
    tick(3);

    // full contention from a fresh pointer
    rst_in = 1'b1; tick(1); rst_in = 1'b0;
    clear_logs();
    offer(0, 8'h11); offer(1, 8'h22); offer(2, 8'h33); offer(3, 8'h44);
    wait_for(0, 5, 200, "contention grants");
    drop_all();
    wait_for(1, 5, 200, "contention dones");
    for (int k = 0; k < 5; k++) chk("contention order", qget(0, k), k % 4);
    chk("contention line0", qget(3, 0), 32'h11);
    chk("contention line1", qget(3, 1), 32'h22);
    chk("contention line2", qget(3, 2), 32'h33);
    chk("contention line3", qget(3, 3), 32'h44);
    chk("contention line4", qget(3, 4), 32'h11);
    for (int k = 1; k < 5; k++) chk("contention no repeat", qget(0, k) != qget(0, k - 1), 1);
    tick(3);

    // pointer wrap: serve 2 so the pointer sits at 3
    clear_logs();
    offer(2, 8'h42);
    wait_for(0, 1, 20, "wrap setup grant");
    drop_all();
    wait_for(1, 1, 60, "wrap setup done");
    tick(2);
    clear_logs();
    offer(0, 8'h5A); offer(3, 8'h3C);
    wait_for(0, 2, 100, "wrap grants");
    drop_all();
    wait_for(1, 2, 100, "wrap dones");
    chk("wrap first grant", qget(0, 0), 3);
    chk("wrap second grant", qget(0, 1), 0);
    chk("wrap grant_id first", qget(4, 0), 3);
    chk("wrap grant_id second", qget(4, 1), 0);
    chk("wrap line0", qget(3, 0), 32'h3C);
    chk("wrap line1", qget(3, 1), 32'h5A);
    tick(3);

    // accept timeout, then the next requester is served
    clear_logs();
    u_en = 1'b0;
    offer(1, 8'h77);
    wait_for(0, 1, 20, "timeout grant");
    @(posedge clk_in); #1;
    req_valid_in[1] = 1'b0;
    offer(2, 8'h99);
    wait_for(2, 1, 40, "timeout err");
    u_en = 1'b1;
    chk("timeout err idx", qget(2, 0), 1);
    chk("timeout err latency", err_cyc - rdy_rise, 16);
    wait_for(0, 2, 20, "timeout next grant");
    drop_all();
    wait_for(1, 1, 60, "timeout next done");
    chk("timeout next idx", qget(0, 1), 2);
    chk("timeout line count", qsize(3), 1);
    chk("timeout line byte", qget(3, 0), 32'h99);
    tick(3);

    // reset in the middle of a frame
    clear_logs();
    offer(2, 8'hC3);
    wait_for(0, 1, 20, "midreset grant");
    drop_all();
    wait_busy("midreset busy");
    tick(3 * BT);
    rst_in = 1'b1;
    offer(1, 8'h81); offer(3, 8'h83);
    tick(1);
    rst_in = 1'b0;
    chk("midreset active", active_out, 0);
    chk("midreset tx_rdy", tx_rdy_out, 0);
    chk("midreset grant_id", grant_id_out, 0);
    chk("midreset done count", qsize(1), 0);
    wait_for(0, 2, 20, "midreset regrant");
    @(posedge clk_in); #1;
    req_valid_in[1] = 1'b0;
    wait_for(0, 3, 80, "midreset third grant");
    drop_all();
    wait_for(1, 2, 120, "midreset dones");
    chk("midreset lowest grant", qget(0, 1), 1);
    chk("midreset done0", qget(1, 0), 1);
    chk("midreset done1", qget(1, 1), 3);
    chk("midreset line0", qget(3, 0), 32'h81);
    chk("midreset line1", qget(3, 1), 32'h83);
    tick(3);

    // short-lived request while the line is busy
    clear_logs();
    offer(0, 8'h10);
    wait_for(0, 1, 20, "drop grant");
    drop_all();
    wait_busy("drop busy");
    offer(1, 8'hEE);
    tick(1);
    req_valid_in[1] = 1'b0;
    wait_for(1, 1, 60, "drop done");
    tick(5);
    chk("drop grant count", qsize(0), 1);
    chk("drop grant idx", qget(0, 0), 0);
    chk("drop line count", qsize(3), 1);
    chk("drop line byte", qget(3, 0), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
